// File: rtl/decoder3_8_scan_pkg.sv
// Shared types and helpers for the 3-to-8 scan decoder and its sibling
// display/keypad blocks.
package decoder_pkg;

   localparam logic [7:0] DOUT_IDLE = 8'hFF;

   typedef enum logic {
      DIRECT = 1'b0,
      SCAN   = 1'b1
   } mode_t;

   // Active-low one-of-eight select: exactly one zero, at position sel.
   function automatic logic [7:0] onecold3(input logic [2:0] sel);
      onecold3 = ~(8'b0000_0001 << sel);
   endfunction

endpackage

// File: rtl/decoder3_8_scan_if.sv
// Enable/control inputs and decoded outputs of the 3-to-8 scan decoder,
// bundled so a board top or bench can hand the whole group over at once.
interface decoder3_8_scan_if;

   logic       G1;
   logic       G2A_n;
   logic       G2B_n;
   logic       mode;
   logic       hold;
   logic [2:0] din;
   logic [7:0] dout;
   logic [2:0] addr_o;
   logic       valid;
   logic       wrap;

   modport master (
      output G1, G2A_n, G2B_n, mode, hold, din,
      input  dout, addr_o, valid, wrap
   );

   modport slave (
      input  G1, G2A_n, G2B_n, mode, hold, din,
      output dout, addr_o, valid, wrap
   );

endinterface

// File: rtl/decoder3_8_scan_tick_gen.sv
// Slot prescaler: counts DIV cycles while run is high and flags the last one.
// Also used by the display and keypad scanners.
module scan_tick_gen #(
   parameter int DIV = 4,
   parameter int PW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          run,
   output logic          tick,
   output logic [PW-1:0] pre
);

   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] r_pre;
   logic          w_tick;

   // clr wins over run so a mode change always restarts the slot from zero.
   assign w_tick = run && !clr && (r_pre == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre <= '0;
      end else if (clr) begin
         r_pre <= '0;
      end else if (run) begin
         if (w_tick) begin
            r_pre <= '0;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

   assign tick = w_tick;
   assign pre  = r_pre;

endmodule

// File: rtl/decoder3_8_scan.sv
// 74HC138-style 3-to-8 decoder with registered active-low outputs and a
// prescaled SCAN mode that walks the select index for keypad rows / digits.
module decoder3_8_scan
   import decoder_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic               clk,
   input  logic               rst,
   decoder3_8_scan_if.slave   bus
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   mode_t         r_state;
   mode_t         w_nextState;
   mode_t         w_modeReq;
   logic [2:0]    r_idx;
   logic [2:0]    w_nextIdx;
   logic [2:0]    w_outIdx;
   logic          w_nextWrap;
   logic [7:0]    r_dout;
   logic [2:0]    r_addr;
   logic          r_valid;
   logic          r_wrap;
   logic          w_en;
   logic          w_scanActive;
   logic          w_run;
   logic          w_clr;
   logic          w_tick;
   logic [PW-1:0] w_pre;

   assign w_en         = bus.G1 & ~bus.G2A_n & ~bus.G2B_n;
   assign w_modeReq    = mode_t'(bus.mode);
   assign w_scanActive = (r_state == SCAN) && (w_modeReq == SCAN);
   assign w_run        = w_scanActive & w_en & ~bus.hold;
   assign w_clr        = ~w_scanActive;

   scan_tick_gen #(
      .DIV (DIV),
      .PW  (PW)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .run  (w_run),
      .tick (w_tick),
      .pre  (w_pre)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DIRECT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Entry into SCAN seeds the index from din; leaving SCAN clears it and
   // decodes din straight away so the outputs never show a stale scan row.
   always_comb begin
      w_nextState = w_modeReq;
      w_nextIdx   = r_idx;
      w_outIdx    = bus.din;
      w_nextWrap  = 1'b0;
      case (r_state)
         DIRECT: begin
            if (w_modeReq == SCAN) begin
               w_nextIdx = bus.din;
            end else begin
               w_nextIdx = 3'd0;
            end
            w_outIdx = bus.din;
         end
         SCAN: begin
            if (w_modeReq == SCAN) begin
               if (w_tick) begin
                  w_nextIdx  = r_idx + 3'd1;
                  w_nextWrap = (r_idx == 3'd7);
               end
               w_outIdx = w_nextIdx;
            end else begin
               w_nextIdx = 3'd0;
               w_outIdx  = bus.din;
            end
         end
         default: begin
            w_nextState = DIRECT;
            w_nextIdx   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= 3'd0;
         r_dout  <= DOUT_IDLE;
         r_addr  <= 3'd0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_idx   <= w_nextIdx;
         r_dout  <= w_en ? onecold3(w_outIdx) : DOUT_IDLE;
         r_addr  <= w_outIdx;
         r_valid <= w_en;
         r_wrap  <= w_nextWrap;
      end
   end

   assign bus.dout   = r_dout;
   assign bus.addr_o = r_addr;
   assign bus.valid  = r_valid;
   assign bus.wrap   = r_wrap;

   // Output invariants: one-cold at most, idle when invalid, prescaler parked in DIRECT.
   a_oneCold: assert property (@(posedge clk) disable iff (rst)
      $countones(~r_dout) <= 1);
   a_idleWhenInvalid: assert property (@(posedge clk) disable iff (rst)
      !r_valid |-> (r_dout == DOUT_IDLE));
   a_prescalerParked: assert property (@(posedge clk) disable iff (rst)
      (r_state == DIRECT) |-> (w_pre == '0));

endmodule

// File: doc/decoder3_8_scan.md
Name: decoder3_8_scan

Overview:
- 74HC138-style 3-to-8 decoder with active-low outputs and three-input enable (G1, G2A_n, G2B_n); the decode-side counterpart to the HC148 8-3 priority encoder.
- Outputs are registered. A scan mode adds a prescaled row/digit walker, so the block can drive keypad rows or LED digit selects.
- Row returns from the driven lines feed the encoder.

Parameters:
- DIV, 4, clock cycles per scan slot in SCAN mode; legal values are DIV >= 1. Use 4 for simulation; the board build sets 50000.
- PW, derived, prescaler width = max(1, $clog2(DIV)).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- G1  in  1  enable, active-high.
- G2A_n  in  1  enable, active-low.
- G2B_n  in  1  enable, active-low.
- mode  in  1  0 = DIRECT decode of din; 1 = SCAN walk.
- hold  in  1  SCAN only: freeze prescaler and index.
- din  in  3  DIRECT-mode address; also the SCAN start index.
- dout  out  8  decoded outputs, active-low; one-cold when enabled.
- addr_o  out  3  index currently decoded onto dout.
- valid  out  1  1 when dout carries a decoded value (enabled).
- wrap  out  1  one-cycle pulse when the scan index advances 7 -> 0.

Behaviour:
- Enable: en = G1 & ~G2A_n & ~G2B_n, sampled each clk.
- Reset (rst=1 at posedge), regardless of other inputs:
  - state = DIRECT; idx = 0; pre = 0.
  - dout = 8'hFF; addr_o = 0; valid = 0; wrap = 0.
- FSM states DIRECT and SCAN; the next state equals mode. The transition takes effect the cycle after mode changes.
- DIRECT:
  - Latency 1. Next dout = en ? ~(8'b1 << din) : 8'hFF.
  - Next addr_o = din; next valid = en.
  - pre is held at 0; wrap = 0.
- DIRECT -> SCAN (first cycle with state=DIRECT and mode=1): idx <= din, pre <= 0, wrap = 0.
- SCAN, counting:
  - tick = (pre == DIV-1). pre <= tick ? 0 : pre+1.
  - On tick: idx <= idx+1 mod 8, and wrap <= (idx == 7), otherwise wrap <= 0.
  - With DIV=1, tick is asserted every cycle.
- Hold and disable in SCAN:
  - hold=1 or en=0 freezes pre and idx; wrap = 0.
  - hold has no effect in DIRECT.
- SCAN outputs (registered from next-state idx, so dout and addr_o change on the same edge as idx):
  - dout = en ? ~(8'b1 << idx) : 8'hFF.
  - addr_o = idx; valid = en.
- SCAN -> DIRECT: idx and pre are cleared; the DIRECT rule applies from the first DIRECT cycle.
- Invariants:
  - dout has at most one zero bit.
  - dout == 8'hFF whenever valid = 0.
  - wrap is never high for two consecutive cycles unless DIV=1.
- Mid-operation reset: synchronous. Any in-progress slot is discarded, and outputs return to reset values at that edge.
- Simultaneous events: rst dominates mode, hold and en; en=0 dominates tick.

Decomposition:
- Package decoder_pkg:
  - DOUT_IDLE = 8'hFF.
  - Enum mode_t {DIRECT, SCAN}.
  - Function onecold3(input [2:0]) returns [7:0].
- Sub-module scan_tick_gen (parameter DIV). Ports: clk, rst, clr, run; outputs tick and pre. Shared with later display and keypad blocks.

Test Plan:
- Reset/idle: hold rst 2 cycles with G1=1 and din=5 -> dout=8'hFF, valid=0, addr_o=0, wrap=0. After release in DIRECT, din=5 -> next cycle dout=8'hDF, addr_o=5, valid=1.
- Enable truth table: sweep all 8 combinations of G1/G2A_n/G2B_n with din=3 -> dout=8'hF7 only for (1,0,0), otherwise 8'hFF with valid=0. Sweep din 0..7 enabled -> dout = FE, FD, FB, F7, EF, DF, BF, 7F.
- Scan walk (DIV=4): din=6, then mode=1 -> idx starts 6 and dout=8'hBF for 4 cycles. Then 8'h7F for 4 cycles, then 8'hFE with wrap=1 for exactly the first cycle of index 0.
- Hold and disable: in SCAN at idx=2, hold=1 for 10 cycles -> dout stays 8'hFB with no tick. Drop G1 for 3 cycles -> dout=8'hFF and valid=0. Restore -> resumes at idx=2 with the prescaler count preserved.
- Mode exit and reset mid-scan: SCAN at idx=4, mode=0 with din=1 -> the cycle after DIRECT takes effect, dout=8'hFD. Separately, assert rst at idx=7 with pre=DIV-1 -> dout=8'hFF with no wrap pulse.
- DIV=1 build: SCAN from din=0 -> dout steps FE, FD, ..., 7F, FE on consecutive cycles, with wrap high on every 8th cycle.
